// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, ALU codes, opcodes, mux selects.
// Pure declarations; no logic, no latency.
// Not applicable (no handshake); consumed by multicycle_control and alu_decoder.
package ctrl_pkg;

    localparam int STATE_W = 4;

    // State codes are plain constants so legacy tools and debug scripts can match on raw values.
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_UPPER    = 4'd8;
    localparam state_t S_ALUWB    = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JAL      = 4'd11;
    localparam state_t S_JALR     = 4'd12;
    localparam state_t S_LINK     = 4'd13;
    localparam state_t S_TRAP     = 4'd14;

    // Coarse ALU request from the FSM; alu_decoder expands it into a full code.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_PASSB = 2'b11
    } aluop_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b1110;
    localparam logic [3:0] ALU_SRA   = 4'b1100;
    localparam logic [3:0] ALU_PASSB = 4'b1101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format depends only on the opcode; R-type and unknown opcodes fall back to I.
    function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_JAL:           sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller (master) and the datapath/memory (slave).
// Wiring only; no latency.
// MemReady is the only flow control: the controller holds its request until it is seen high.
interface multicycle_control_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int STATE_W     = 4
);
    // datapath -> controller
    logic [INSTR_WIDTH-1:0] Instr;
    logic                   Zero;
    logic                   SignedSmaller;
    logic                   UnsignedSmaller;
    logic                   MemReady;
    // controller -> datapath
    logic                   PCWrite;
    logic                   AdrSrc;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic                   RegWrite;
    logic [1:0]             ResultSrc;
    logic [1:0]             ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [3:0]             ALUControl;
    logic [2:0]             ImmSrc;
    logic                   Illegal;
    logic [STATE_W-1:0]     State;

    modport master (
        input  Instr, Zero, SignedSmaller, UnsignedSmaller, MemReady,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
    );

    modport slave (
        output Instr, Zero, SignedSmaller, UnsignedSmaller, MemReady,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
    );
endinterface

// File: rtl/alu_decoder.sv
// Expands the FSM's coarse ALU request plus funct3/Instr[30] into the 4-bit ALU code.
// Purely combinational, zero latency.
// No handshake.
// Ports: alu_op (add/sub/funct/passB), funct3, funct7b5 (Instr[30]), is_rtype -> alu_control.
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e     alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_PASSB: alu_control = ALU_PASSB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Instr[30] is an immediate bit for addi, so only R-type may select sub.
                    3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    // srai keeps Instr[30] as a real funct7 bit, so no R-type qualifier here.
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore main controller for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// 3-5 cycles per instruction with MemReady=1 (branch 3, load 5, others 4); outputs decode from state.
// Memory accesses hold MemRead/MemWrite and AdrSrc stable and stall one cycle per MemReady=0.
// Ports: clk, rst (sync, active-high); bus (master modport) carries Instr, ALU flags, MemReady in and
// the PC/IR/register/memory enables, mux selects, ALUControl, ImmSrc, sticky Illegal and State out.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int STATE_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    logic   illegal_q;

    logic [INSTR_WIDTH-1:0] instr;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   funct7b5;
    logic                   is_rtype;

    assign instr    = bus.Instr;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign is_rtype = (opcode == OP_RTYPE);

    // Register indices and most immediate bits belong to the datapath, not the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

    // Branch resolution from the ALU flags of RD1 - RD2.
    logic taken;
    logic bad_branch;
    always_comb begin
        taken      = 1'b0;
        bad_branch = 1'b0;
        case (funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = !bus.Zero;
            3'b100:  taken = bus.SignedSmaller;
            3'b101:  taken = !bus.SignedSmaller;
            3'b110:  taken = bus.UnsignedSmaller;
            3'b111:  taken = !bus.UnsignedSmaller;
            default: bad_branch = 1'b1;
        endcase
    end

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    aluop_e     alu_op;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed when the read completes.
                mem_read   = 1'b1;
                src_a      = SRCA_PC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative OldPC+imm lands in ALUOut for branch/JAL to use next cycle.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_IMM;
                // Only loads and stores reach here; opcode bit 5 separates them.
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_read   = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RD1;
                src_b   = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_UPPER: begin
                src_b = SRCB_IMM;
                if (opcode == OP_LUI) begin
                    alu_op = ALUOP_PASSB;
                end else begin
                    src_a  = SRCA_OLDPC;
                    alu_op = ALUOP_ADD;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                if (bad_branch) begin
                    state_d = S_TRAP;
                end else begin
                    pc_write = taken;
                    state_d  = S_FETCH;
                end
            end
            S_JAL: begin
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_JALR: begin
                // The datapath clears bit 0 of the target on its way into the PC.
                src_a      = SRCA_RD1;
                src_b      = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (is_rtype),
        .alu_control (bus.ALUControl)
    );

    // Architectural side effects are suppressed in the reset cycle whatever state is current.
    assign bus.PCWrite   = pc_write  & ~rst;
    assign bus.IRWrite   = ir_write  & ~rst;
    assign bus.RegWrite  = reg_write & ~rst;
    assign bus.MemRead   = mem_read  & ~rst;
    assign bus.MemWrite  = mem_write & ~rst;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.ImmSrc    = imm_sel(opcode);
    assign bus.Illegal   = illegal_q;
    assign bus.State     = STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main controller for the multicycle RV32I datapath.
- Drives the ALU's 4-bit operation code and datapath mux selects and write enables.
- Consumes the ALU's Zero, SignedSmaller and UnsignedSmaller flags to resolve branches.
- Sequences fetch/decode/execute/memory/writeback and handshakes the unified memory through MemReady.

Parameters:
- INSTR_WIDTH, 32, instruction register width (fixed RV32).
- STATE_W, 4, width of the State debug output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- Instr  in  32  instruction register contents.
- Zero  in  1  ALU result == 0.
- SignedSmaller  in  1  ALU signed A<B.
- UnsignedSmaller  in  1  ALU unsigned A<B.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  PC <= Result.
- AdrSrc  out  1  memory address select: 0 PC, 1 Result.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR <= ReadData, OldPC <= PC.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  ALU B select: 00 RD2, 01 ImmExt, 10 const 4.
- ALUControl  out  4  ALU operation code.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- Illegal  out  1  sticky illegal-instruction flag.
- State  out  STATE_W  current state, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset:
  - State <= FETCH and Illegal <= 0.
  - While rst=1, PCWrite, IRWrite, RegWrite, MemRead and MemWrite are forced 0.
  - After reset, the other outputs take their FETCH values.
- ALU codes: add 0000, sub 1000, and 0010, or 0011, xor 0100, slt 0101, sltu 0111, sll 0110, srl 1110, sra 1100, passB 1101.
- States and outputs (unlisted enables are 0):
  - FETCH: AdrSrc=0, MemRead=1.
    - MemReady=1: IRWrite=1, PCWrite=1, SrcA=PC, SrcB=4, add, ResultSrc=10, go to DECODE.
    - Otherwise hold with no enables.
  - DECODE: SrcA=OldPC, SrcB=Imm, add (branch/JAL target into ALUOut). Dispatch on opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 or 0010111 -> UPPER
    - anything else -> TRAP
  - MEMADR: SrcA=RD1, SrcB=Imm, add. Go to MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD: AdrSrc=1, ResultSrc=00, MemRead=1. Hold until MemReady, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Hold until MemReady, then FETCH.
  - EXECR: SrcA=RD1, SrcB=RD2, funct decode, then ALUWB.
  - EXECI: SrcA=RD1, SrcB=Imm, funct decode, then ALUWB.
  - UPPER: SrcB=Imm.
    - LUI: passB.
    - AUIPC: SrcA=OldPC, add.
    - Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - BRANCH: SrcA=RD1, SrcB=RD2, sub, ResultSrc=00, PCWrite=taken, then FETCH. Taken by funct3:
    - 000: Zero
    - 001: !Zero
    - 100: SignedSmaller
    - 101: !SignedSmaller
    - 110: UnsignedSmaller
    - 111: !UnsignedSmaller
    - 010/011: not a branch; go to TRAP, no PCWrite.
  - JAL: ResultSrc=00, PCWrite=1, then LINK.
  - JALR: SrcA=RD1, SrcB=Imm, add, ResultSrc=10, PCWrite=1, then LINK. The datapath clears bit 0.
  - LINK: SrcA=OldPC, SrcB=4, add, ResultSrc=10, RegWrite=1, then FETCH.
  - TRAP: all enables 0, Illegal=1. Held until rst.
- Funct decode, by funct3:
  - 000: add; sub only when R-type and Instr[30]=1.
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: srl, or sra when Instr[30]=1.
  - 110: or
  - 111: and
- ImmSrc: decoded combinationally from the opcode in every state. Unknown opcode gives 000.
- Cycle counts with MemReady=1: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL/JALR 4.
- Boundary conditions:
  - Each cycle MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - MemRead/MemWrite stay high, and the address select stays stable, while waiting.
  - rst mid-instruction: the next edge returns to FETCH; no write enable is asserted in the rst cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum;
  - ALU operation code constants;
  - opcode constants;
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- Sub-module alu_decoder (combinational): ALUOp[1:0] (00 add, 01 sub, 10 funct, 11 passB), funct3, Instr[30] and isRtype -> ALUControl.

Test Plan:
- add x3,x1,x2 (0x002081B3) with MemReady=1:
  - States FETCH, DECODE, EXECR, ALUWB.
  - ALUControl=1000 is never seen.
  - RegWrite=1 only in cycle 4.
  - FETCH asserts IRWrite and PCWrite once.
- sub (0x402081B3) -> EXECR ALUControl=1000. srai (0x4020D193) -> EXECI ALUControl=1100, ALUSrcB=01.
- beq (0x00208463):
  - Zero=1 -> PCWrite=1 in BRANCH with ResultSrc=00.
  - Zero=0 -> PCWrite=0.
  - bltu with UnsignedSmaller=1 -> taken.
- lw (0x0000A183) with MemReady low for 2 cycles in MEMREAD:
  - MemRead and AdrSrc=1 held for 3 cycles.
  - Then MEMWB, RegWrite=1, ResultSrc=01.
  - Total 7 cycles.
- jalr (0x000080E7):
  - JALR: PCWrite=1, ResultSrc=10.
  - LINK: RegWrite=1, ALUSrcA=01, ALUSrcB=10.
  - LUI (0x123450B7) -> ALUControl=1101, ImmSrc=100.
- Opcode 0x0000007F:
  - DECODE -> TRAP, Illegal=1 held for 10 cycles with no enables.
  - rst=1 for one cycle -> FETCH, Illegal=0.
